reg_writeback_unit: RTL and testbench
=====================================

# reg_writeback_unit

Writeback stage feeding the register-file write port. Accepts one retiring instruction at a time from execute/memory and selects the writeback source: ALU result, PC+4 or aligned load data. For loads it waits on the data-memory read response. It drives `write_en`/`write_addr`/`write_value` into the register file, the opposite end of the operand-read path in decode.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `CNT_W`, 64: retired-instruction counter width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: retiring instruction present.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `in_wb_sel` in 2: source select (`WB_X`, `WB_ALU`, `WB_MEM`, `WB_PC`).
- `in_rf_wen` in 1: instruction writes rd.
- `in_rd` in 5: destination register.
- `in_alu_out` in XLEN: ALU result; for loads, the byte address.
- `in_pc` in XLEN: instruction PC.
- `in_funct3` in 3: load width/sign (`LD_B`=000, `LD_H`=001, `LD_W`=010, `LD_BU`=100, `LD_HU`=101).
- `mem_rvalid` in 1: load data valid.
- `mem_rdata` in XLEN: aligned 32-bit word containing the load.
- `write_en` out 1: register-file write strobe.
- `write_addr` out 5: write register index.
- `write_value` out XLEN: write data.
- `load_fault` out 1: one-cycle pulse for a misaligned load or illegal funct3.
- `spurious_rvalid` out 1: sticky; `mem_rvalid` seen in IDLE.
- `retired` out CNT_W: completed-instruction count.

## Operation
- FSM states: IDLE, WAIT_MEM.
- In IDLE, a transfer occurs when `in_valid && in_ready`:
  - `WB_ALU`: value = `in_alu_out`. `WB_PC`: value = `in_pc + 4`, modulo 2^XLEN. `WB_X`: no value.
  - Each of these completes at the same edge and the state stays IDLE.
  - `WB_MEM`: latch rd, `rf_wen`, funct3 and `addr[1:0]`; go to WAIT_MEM.
- In WAIT_MEM, `in_ready`=0 and inputs are ignored.
  - On `mem_rvalid`: extract and complete, then return to IDLE.
  - No timeout.
- Load extract:
  - Byte select is `addr[1:0]*8`; halfword select is `addr[1]*16`.
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - Misaligned cases: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
- Completion of a non-faulting instruction:
  - `write_en` = `rf_wen && rd≠0`.
  - `write_addr` = rd and `write_value` = value (registered).
  - `retired` += 1, including `rf_wen`=0 and rd=0 cases.
- Faulting load (misaligned or funct3 ∉ {000,001,010,100,101}):
  - The fault is detected when `mem_rvalid` arrives.
  - `write_en`=0, `load_fault` pulses, `retired` does not increment, and the state returns to IDLE.
- `mem_rvalid` in IDLE: ignored for data; sets `spurious_rvalid` (cleared only by `rst`).
- `write_en` and `load_fault` are single-cycle pulses; `write_addr`/`write_value` hold their last values otherwise.

## Timing
- Reset values: state IDLE, `in_ready`=1 in the following cycle, `write_en`=0, `write_addr`=0, `write_value`=0, `load_fault`=0, `spurious_rvalid`=0, `retired`=0.
- Non-load accepted at edge N: `write_en` high during cycle N+1 (latency 1).
  - Back-to-back non-loads sustain 1 per cycle.
- Load accepted at edge N: WAIT_MEM from N+1; earliest `mem_rvalid` is sampled at edge N+1.
  - If `mem_rvalid` is sampled at edge M, `write_en` is high during M+1.
  - `in_ready` is high again during M+1; the next transfer is at edge M+1 at the earliest.
- `rst` during WAIT_MEM: the pending load is dropped with no write and no count; a later `mem_rvalid` then sets `spurious_rvalid`.
- `rst` wins over a simultaneous transfer or `mem_rvalid`.
- The register file updates on the edge after `write_en`. A decode read of the same register at that edge returns the old value; bypassing is decode's responsibility.

## Structure
- Shared defines/package: `WB_X`=0, `WB_ALU`=1, `WB_MEM`=2, `WB_PC`=3; the `LD_*` funct3 codes; state encodings. These sit alongside the existing `OP1_*`/`OP2_*` constants.
- One combinational sub-module, `load_extract`, with inputs (word, funct3, `addr[1:0]`) and outputs (value, fault).
- FSM, output registers and counter live in the top module.

## Test plan
- ALU write: `in_wb_sel`=`WB_ALU`, rd=5, `alu_out`=0x1234 at edge N → cycle N+1 `write_en`=1, addr=5, value=0x1234; `retired`=1.
- x0 and PC+4: rd=0 with `WB_ALU` → `write_en`=0 but `retired` increments. `WB_PC` with pc=0xFFFFFFFC, rd=1 → value=0x00000000.
- Loads: LB with addr=...3 and rdata=0x80FF_0000 → 0xFFFFFF80. LHU with addr=...2 → 0x000080FF. LW with 3 wait cycles → write exactly 1 cycle after `mem_rvalid`, and `in_ready` low throughout the wait.
- Faults: LH with addr=...1, and funct3=011 → `load_fault` pulse, no write, `retired` unchanged, then back to IDLE.
- Reset mid-load: `rst` during WAIT_MEM then `mem_rvalid` → no write and `spurious_rvalid`=1; all outputs at their reset values during the reset cycle.
- Throughput: 4 back-to-back ALU ops → 4 consecutive `write_en` cycles and `retired`=4.

Source files
------------

// File: rtl/reg_writeback_unit_pkg.sv
// Shared encodings for the writeback stage: source selects, load funct3 codes,
// FSM states and the latched load context.
package reg_writeback_unit_pkg;

    typedef enum logic [1:0] {
        WB_X   = 2'd0,
        WB_ALU = 2'd1,
        WB_MEM = 2'd2,
        WB_PC  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic       rf_wen;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } pend_load_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Retire-side handshake, data-memory read response and register-file write port.
interface reg_writeback_unit_if #(parameter int XLEN = 32);
    import reg_writeback_unit_pkg::*;

    logic            in_valid;
    logic            in_ready;
    wb_sel_e         in_wb_sel;
    logic            in_rf_wen;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_alu_out;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_funct3;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            write_en;
    logic [4:0]      write_addr;
    logic [XLEN-1:0] write_value;

    modport master (
        output in_valid, in_wb_sel, in_rf_wen, in_rd, in_alu_out, in_pc, in_funct3,
        output mem_rvalid, mem_rdata,
        input  in_ready, write_en, write_addr, write_value
    );

    modport slave (
        input  in_valid, in_wb_sel, in_rf_wen, in_rd, in_alu_out, in_pc, in_funct3,
        input  mem_rvalid, mem_rdata,
        output in_ready, write_en, write_addr, write_value
    );

endinterface

// File: rtl/reg_writeback_unit_load_extract.sv
// Pulls a byte/halfword/word out of an aligned memory word and flags
// misaligned accesses or unknown load encodings.
module load_extract
    import reg_writeback_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] value,
    output logic            fault
);

    logic [4:0]  byte_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_shift = {addr_lo, 3'b000};
    assign byte_sel   = word[byte_shift +: 8];
    assign half_sel   = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        value = '0;
        fault = 1'b0;
        case (funct3)
            LD_B:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_BU: value = {{(XLEN-8){1'b0}}, byte_sel};
            LD_H: begin
                value = {{(XLEN-16){half_sel[15]}}, half_sel};
                fault = addr_lo[0];
            end
            LD_HU: begin
                value = {{(XLEN-16){1'b0}}, half_sel};
                fault = addr_lo[0];
            end
            LD_W: begin
                value = word;
                fault = (addr_lo != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage: picks ALU / PC+4 / load data, waits on memory for loads,
// and drives the register-file write port plus a retired-instruction count.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_writeback_unit_if.slave  bus,
    output logic                 load_fault,
    output logic                 spurious_rvalid,
    output logic [CNT_W-1:0]     retired
);

    wb_state_e       state, next_state;
    pend_load_t      pend_q, pend_d;
    logic            done;
    logic            fault;
    logic [4:0]      done_rd;
    logic            done_wen;
    logic [XLEN-1:0] done_value;
    logic [XLEN-1:0] ext_value;
    logic            ext_fault;

    load_extract #(.XLEN(XLEN)) u_extract (
        .word    (bus.mem_rdata),
        .funct3  (pend_q.funct3),
        .addr_lo (pend_q.addr_lo),
        .value   (ext_value),
        .fault   (ext_fault)
    );

    assign bus.in_ready = (state == S_IDLE);

    always_comb begin
        next_state = state;
        pend_d     = pend_q;
        done       = 1'b0;
        fault      = 1'b0;
        done_rd    = bus.in_rd;
        done_wen   = bus.in_rf_wen;
        done_value = '0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    case (bus.in_wb_sel)
                        WB_ALU: begin
                            done       = 1'b1;
                            done_value = bus.in_alu_out;
                        end
                        WB_PC: begin
                            done       = 1'b1;
                            done_value = bus.in_pc + XLEN'(4);
                        end
                        WB_MEM: begin
                            next_state = S_WAIT_MEM;
                            pend_d     = '{rf_wen:  bus.in_rf_wen,
                                           rd:      bus.in_rd,
                                           funct3:  bus.in_funct3,
                                           addr_lo: bus.in_alu_out[1:0]};
                        end
                        default: done = 1'b1;
                    endcase
                end
            end
            S_WAIT_MEM: begin
                done_rd    = pend_q.rd;
                done_wen   = pend_q.rf_wen;
                done_value = ext_value;
                if (bus.mem_rvalid) begin
                    next_state = S_IDLE;
                    fault      = ext_fault;
                    done       = !ext_fault;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // takes priority over any transfer or memory response on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pend_q          <= '0;
            bus.write_en    <= 1'b0;
            bus.write_addr  <= '0;
            bus.write_value <= '0;
            load_fault      <= 1'b0;
            spurious_rvalid <= 1'b0;
            retired         <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state        <= next_state;
            pend_q       <= pend_d;
            bus.write_en <= done && done_wen && (done_rd != 5'd0);
            load_fault   <= fault;
            if (done) begin
                bus.write_addr  <= done_rd;
                bus.write_value <= done_value;
                retired         <= retired + CNT_W'(1);
            end
            if (state == S_IDLE && bus.mem_rvalid) begin
                spurious_rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_fault;
    logic        spurious_rvalid;
    logic [63:0] retired;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [63:0] exp_retired  = 64'd0;

    reg_writeback_unit_if #(.XLEN(32)) bus ();

    reg_writeback_unit #(.XLEN(32), .CNT_W(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .load_fault      (load_fault),
        .spurious_rvalid (spurious_rvalid),
        .retired         (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: architectural load semantics from plain shifts, masks and arithmetic.
    function automatic void ref_load(input logic [31:0] word, input logic [2:0] f3,
                                     input logic [1:0] a, output logic [31:0] val,
                                     output logic flt);
        int unsigned sh;
        logic [31:0] b;
        logic [31:0] h;
        sh  = a * 8;
        b   = (word >> sh) & 32'hFF;
        h   = (word >> sh) & 32'hFFFF;
        val = 32'd0;
        flt = 1'b0;
        case (f3)
            3'd0: val = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4: val = b;
            3'd1: begin flt = (a % 2) != 0; val = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
            3'd5: begin flt = (a % 2) != 0; val = h; end
            3'd2: begin flt = (a != 0); val = word; end
            default: flt = 1'b1;
        endcase
    endfunction

    task automatic issue(input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
        int budget;
        budget         = 0;
        bus.in_valid   = 1'b1;
        bus.in_wb_sel  = wb_sel_e'(sel);
        bus.in_rf_wen  = wen;
        bus.in_rd      = rd;
        bus.in_alu_out = alu;
        bus.in_pc      = pc;
        bus.in_funct3  = f3;
        while (!bus.in_ready && budget < 20) begin
            step();
            budget++;
        end
        if (budget >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL issue_timeout: in_ready stayed %0b, want 1 within 20 cycles", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic mem_respond(input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) begin
            tests_run++;
            if (bus.in_ready !== 1'b0 || bus.write_en !== 1'b0) begin
                tests_failed++;
                $display("FAIL wait_mem_idle: in_ready=%0b write_en=%0b, want 0 0", bus.in_ready, bus.write_en);
            end
            step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        step();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue(WB_ALU, 1'b1, 5'd3, 32'hAAAA_5555, 32'd0, 3'd0);
        step();
        tests_run++;
        if ({bus.write_en, bus.write_addr, bus.write_value, load_fault, spurious_rvalid, retired}
            !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 64'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: en=%0b addr=%0d val=%h flt=%0b spur=%0b ret=%0d, want all 0",
                     bus.write_en, bus.write_addr, bus.write_value, load_fault, spurious_rvalid, retired);
        end
        rst = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: in_ready=%0b, want 1", bus.in_ready);
        end
        exp_retired = 64'd0;
    endtask

    task automatic test_alu_write();
        issue(WB_ALU, 1'b1, 5'd5, 32'h0000_1234, 32'd0, 3'd0);
        exp_retired++;
        tests_run++;
        if ({bus.write_en, bus.write_addr, bus.write_value} !== {1'b1, 5'd5, 32'h0000_1234}) begin
            tests_failed++;
            $display("FAIL alu_write: en=%0b addr=%0d val=%h, want 1 5 00001234",
                     bus.write_en, bus.write_addr, bus.write_value);
        end
        tests_run++;
        if (retired !== exp_retired) begin
            tests_failed++;
            $display("FAIL alu_retired: got %0d, want %0d", retired, exp_retired);
        end
        step();
        tests_run++;
        if (bus.write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_pulse: write_en=%0b, want 0", bus.write_en);
        end
    endtask

    task automatic test_x0_pc();
        issue(WB_ALU, 1'b1, 5'd0, 32'hCAFE_F00D, 32'd0, 3'd0);
        exp_retired++;
        tests_run++;
        if (bus.write_en !== 1'b0 || retired !== exp_retired) begin
            tests_failed++;
            $display("FAIL x0_write: en=%0b ret=%0d, want 0 %0d", bus.write_en, retired, exp_retired);
        end
        issue(WB_PC, 1'b1, 5'd1, 32'd0, 32'hFFFF_FFFC, 3'd0);
        exp_retired++;
        tests_run++;
        if ({bus.write_en, bus.write_addr, bus.write_value} !== {1'b1, 5'd1, 32'h0000_0000}) begin
            tests_failed++;
            $display("FAIL pc_wrap: en=%0b addr=%0d val=%h, want 1 1 00000000",
                     bus.write_en, bus.write_addr, bus.write_value);
        end
    endtask

    task automatic test_loads();
        issue(WB_MEM, 1'b1, 5'd7, 32'h0000_1003, 32'd0, LD_B);
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_busy: in_ready=%0b, want 0", bus.in_ready);
        end
        mem_respond(0, 32'h80FF_0000);
        exp_retired++;
        tests_run++;
        if ({bus.write_en, bus.write_addr, bus.write_value} !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin
            tests_failed++;
            $display("FAIL lb_sext: en=%0b addr=%0d val=%h, want 1 7 ffffff80",
                     bus.write_en, bus.write_addr, bus.write_value);
        end
        issue(WB_MEM, 1'b1, 5'd8, 32'h0000_2002, 32'd0, LD_HU);
        mem_respond(1, 32'h80FF_0000);
        exp_retired++;
        tests_run++;
        if ({bus.write_en, bus.write_addr, bus.write_value} !== {1'b1, 5'd8, 32'h0000_80FF}) begin
            tests_failed++;
            $display("FAIL lhu_zext: en=%0b addr=%0d val=%h, want 1 8 000080ff",
                     bus.write_en, bus.write_addr, bus.write_value);
        end
        issue(WB_MEM, 1'b1, 5'd9, 32'h0000_3000, 32'd0, LD_W);
        mem_respond(3, 32'hDEAD_BEEF);
        exp_retired++;
        tests_run++;
        if ({bus.write_en, bus.write_addr, bus.write_value, bus.in_ready}
            !== {1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1}) begin
            tests_failed++;
            $display("FAIL lw_wait: en=%0b addr=%0d val=%h rdy=%0b, want 1 9 deadbeef 1",
                     bus.write_en, bus.write_addr, bus.write_value, bus.in_ready);
        end
        step();
        tests_run++;
        if (bus.write_en !== 1'b0 || retired !== exp_retired) begin
            tests_failed++;
            $display("FAIL lw_after: en=%0b ret=%0d, want 0 %0d", bus.write_en, retired, exp_retired);
        end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [2];
        logic [2:0]  f3s   [2];
        addrs[0] = 32'h0000_4001; f3s[0] = LD_H;
        addrs[1] = 32'h0000_4000; f3s[1] = 3'b011;
        for (int i = 0; i < 2; i++) begin
            issue(WB_MEM, 1'b1, 5'd10, addrs[i], 32'd0, f3s[i]);
            mem_respond(1, 32'h1234_5678);
            tests_run++;
            if ({bus.write_en, load_fault, bus.in_ready} !== 3'b011 || retired !== exp_retired) begin
                tests_failed++;
                $display("FAIL fault_%0d: en=%0b flt=%0b rdy=%0b ret=%0d, want 0 1 1 %0d",
                         i, bus.write_en, load_fault, bus.in_ready, retired, exp_retired);
            end
            step();
            tests_run++;
            if (load_fault !== 1'b0) begin
                tests_failed++;
                $display("FAIL fault_pulse_%0d: load_fault=%0b, want 0", i, load_fault);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds  [4];
        logic [31:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            rds[i]  = 5'(11 + i);
            vals[i] = $urandom;
        end
        bus.in_valid  = 1'b1;
        bus.in_wb_sel = WB_ALU;
        bus.in_rf_wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_rd      = rds[i];
            bus.in_alu_out = vals[i];
            step();
            exp_retired++;
            tests_run++;
            if ({bus.write_en, bus.write_addr, bus.write_value} !== {1'b1, rds[i], vals[i]}) begin
                tests_failed++;
                $display("FAIL b2b_%0d: en=%0b addr=%0d val=%h, want 1 %0d %h",
                         i, bus.write_en, bus.write_addr, bus.write_value, rds[i], vals[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
        tests_run++;
        if (bus.write_en !== 1'b0 || retired !== exp_retired) begin
            tests_failed++;
            $display("FAIL b2b_end: en=%0b ret=%0d, want 0 %0d", bus.write_en, retired, exp_retired);
        end
    endtask

    task automatic test_reset_mid_load();
        issue(WB_MEM, 1'b1, 5'd12, 32'h0000_5000, 32'd0, LD_W);
        rst            = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        step();
        tests_run++;
        if ({bus.write_en, bus.write_addr, bus.write_value, load_fault, spurious_rvalid, retired}
            !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 64'd0}) begin
            tests_failed++;
            $display("FAIL midload_reset: en=%0b addr=%0d val=%h flt=%0b spur=%0b ret=%0d, want all 0",
                     bus.write_en, bus.write_addr, bus.write_value, load_fault, spurious_rvalid, retired);
        end
        exp_retired = 64'd0;
        rst = 1'b0;
        step();
        bus.mem_rvalid = 1'b0;
        tests_run++;
        if ({bus.write_en, spurious_rvalid} !== 2'b01 || retired !== exp_retired) begin
            tests_failed++;
            $display("FAIL midload_spurious: en=%0b spur=%0b ret=%0d, want 0 1 0",
                     bus.write_en, spurious_rvalid, retired);
        end
        step();
        tests_run++;
        if (spurious_rvalid !== 1'b1 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL spurious_sticky: spur=%0b rdy=%0b, want 1 1", spurious_rvalid, bus.in_ready);
        end
    endtask

    task automatic test_random();
        logic [1:0]  sel;
        logic        wen, exp_we, exp_flt;
        logic [4:0]  rd;
        logic [31:0] alu, pc, data, exp_val;
        logic [2:0]  f3;
        for (int n = 0; n < 40; n++) begin
            sel     = 2'($urandom_range(0, 3));
            rd      = 5'($urandom_range(0, 31));
            wen     = (sel == WB_X) ? 1'b0 : 1'($urandom_range(0, 1));
            alu     = $urandom;
            pc      = $urandom;
            f3      = 3'($urandom_range(0, 7));
            data    = $urandom;
            exp_flt = 1'b0;
            exp_val = 32'd0;
            issue(sel, wen, rd, alu, pc, f3);
            if (sel == WB_MEM) begin
                mem_respond(int'($urandom_range(0, 3)), data);
                ref_load(data, f3, alu[1:0], exp_val, exp_flt);
            end else if (sel == WB_ALU) begin
                exp_val = alu;
            end else if (sel == WB_PC) begin
                exp_val = pc + 32'd4;
            end
            exp_we = !exp_flt && wen && (rd != 5'd0);
            if (!exp_flt) exp_retired++;
            tests_run++;
            if (bus.write_en !== exp_we || load_fault !== exp_flt || retired !== exp_retired) begin
                tests_failed++;
                $display("FAIL rand_%0d ctl: en=%0b flt=%0b ret=%0d, want %0b %0b %0d",
                         n, bus.write_en, load_fault, retired, exp_we, exp_flt, exp_retired);
            end
            if (exp_we) begin
                tests_run++;
                if (bus.write_addr !== rd || bus.write_value !== exp_val) begin
                    tests_failed++;
                    $display("FAIL rand_%0d data: addr=%0d val=%h, want %0d %h",
                             n, bus.write_addr, bus.write_value, rd, exp_val);
                end
            end
        end
        tests_run++;
        if (spurious_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rand_spurious: spur=%0b, want 1", spurious_rvalid);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_wb_sel  = WB_X;
        bus.in_rf_wen  = 1'b0;
        bus.in_rd      = 5'd0;
        bus.in_alu_out = 32'd0;
        bus.in_pc      = 32'd0;
        bus.in_funct3  = 3'd0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        step();
        test_reset();
        test_alu_write();
        test_x0_pc();
        test_loads();
        test_faults();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
